eight_bit_adder_unit: RTL and testbench

//  - 8-bit ripple-carry adder of the relay-computer ALU; sums registers B and C.
//  - Models the relay adder's power rail: the adder produces a result only when V is energised.
//  - Result and carry-out are registered once per clock and feed the ALU output mux and the carry flag.

---
 rtl/eight_bit_adder_unit_pkg.sv | 9 +
 rtl/eight_bit_adder_unit_if.sv | 31 +++
 rtl/eight_bit_adder_unit_relay_fa.sv | 17 +
 rtl/eight_bit_adder_unit.sv | 65 ++++++
 tb/tb_eight_bit_adder_unit.sv | 117 +++++++++++
 5 files changed

// File: rtl/eight_bit_adder_unit_pkg.sv
// Shared definitions for the relay-computer ALU datapath.
// Operand and result bytes are carried as relay_byte_t throughout the ALU.
package relay_pkg;

  localparam int RELAY_WIDTH = 8;

  typedef logic [RELAY_WIDTH-1:0] relay_byte_t;

endpackage : relay_pkg

// File: rtl/eight_bit_adder_unit_if.sv
// Operand/result bundle between the ALU register file and the relay adder.
// The master drives the power rail and operands; the slave (adder) returns sum and carry.
interface eight_bit_adder_unit_if
  import relay_pkg::*;
#(
  parameter int WIDTH = RELAY_WIDTH
);

  logic             V;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] adder_out;
  logic             carry;

  modport master (
    output V,
    output b,
    output c,
    input  adder_out,
    input  carry
  );

  modport slave (
    input  V,
    input  b,
    input  c,
    output adder_out,
    output carry
  );

endinterface : eight_bit_adder_unit_if

// File: rtl/eight_bit_adder_unit_relay_fa.sv
// One power-gated relay full-adder stage of the ripple chain.
// With the rail de-energised both outputs are forced low, which also blocks X on the operands.
module relay_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic v,
  output logic sum,
  output logic cout
);

  always_comb begin
    sum  = v & (a ^ b ^ cin);
    cout = v & ((a & b) | (cin & (a ^ b)));
  end

endmodule : relay_full_adder

// File: rtl/eight_bit_adder_unit.sv
// Relay ALU adder: WIDTH-stage power-gated ripple chain summing B and C,
// with sum and carry-out registered once per clock.
module eight_bit_adder_unit
  import relay_pkg::*;
#(
  parameter int WIDTH = RELAY_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eight_bit_adder_unit_if.slave bus
);

  logic [WIDTH-1:0] sum_stage;
  logic             carry_msb;

  logic [WIDTH-1:0] adder_out_d;
  logic [WIDTH-1:0] adder_out_q;
  logic             carry_d;
  logic             carry_q;

  // Each stage owns its carry wires so the chain is a plain forward path, stage to stage.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    logic cin;
    logic cout;
    logic sum;

    if (gi == 0) begin : g_first
      assign cin = 1'b0;
    end else begin : g_rest
      assign cin = g_stage[gi-1].cout;
    end

    relay_full_adder u_fa (
      .a    (bus.b[gi]),
      .b    (bus.c[gi]),
      .cin  (cin),
      .v    (bus.V),
      .sum  (sum),
      .cout (cout)
    );

    assign sum_stage[gi] = sum;
  end

  assign carry_msb = g_stage[WIDTH-1].cout;

  always_comb begin
    adder_out_d = sum_stage;
    carry_d     = carry_msb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adder_out_q <= '0;
      carry_q     <= 1'b0;
    end else begin
      adder_out_q <= adder_out_d;
      carry_q     <= carry_d;
    end
  end

  assign bus.adder_out = adder_out_q;
  assign bus.carry     = carry_q;

endmodule : eight_bit_adder_unit

// File: tb/tb_eight_bit_adder_unit.sv
// Directed and random checks of the registered relay adder: reset, sums, wrap, power gating.
module tb_eight_bit_adder_unit;
  import relay_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  eight_bit_adder_unit_if bus ();

  eight_bit_adder_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [8:0] actual, input logic [8:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[%0t] FAIL %s : got {carry,sum}=%h, expected %h", $time, tag, actual, expected);
    end else begin
      $display("[%0t] ok   %s : {carry,sum}=%h", $time, tag, actual);
    end
  endtask

  // Drive inputs just after an edge, let the next edge sample them, then look 1 ns later.
  task automatic apply(input logic v, input relay_byte_t b, input relay_byte_t c);
    bus.V = v;
    bus.b = b;
    bus.c = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] observed();
    return {bus.carry, bus.adder_out};
  endfunction

  initial begin
    #200000;
    $display("[%0t] FAIL watchdog : simulation did not finish, required end of test", $time);
    $fatal(1, "timeout");
  end

  initial begin
    relay_byte_t rb;
    relay_byte_t rc;
    n_checks = 0;
    n_fail   = 0;

    rst_n = 1'b0;
    apply(1'b1, 8'hAA, 8'h55);
    check_eq("reset_cycle1", observed(), 9'h000);
    apply(1'b1, 8'hAA, 8'h55);
    check_eq("reset_cycle2", observed(), 9'h000);

    rst_n = 1'b1;
    apply(1'b1, 8'h00, 8'h01);
    check_eq("00+01", observed(), 9'h001);
    @(negedge clk);
    check_eq("hold_between_edges", observed(), 9'h001);
    @(posedge clk);
    #1;
    apply(1'b1, 8'h01, 8'h01);
    check_eq("01+01", observed(), 9'h002);
    apply(1'b1, 8'hFF, 8'h01);
    check_eq("FF+01_wrap", observed(), 9'h100);
    apply(1'b1, 8'hFF, 8'hFF);
    check_eq("FF+FF", observed(), 9'h1FE);
    apply(1'b1, 8'h7F, 8'h01);
    check_eq("7F+01_ripple", observed(), 9'h080);
    apply(1'b1, 8'h00, 8'h00);
    check_eq("00+00", observed(), 9'h000);
    apply(1'b1, 8'hA5, 8'h5A);
    check_eq("A5+5A", observed(), 9'h0FF);

    apply(1'b0, 8'h12, 8'h34);
    check_eq("V0_12+34", observed(), 9'h000);
    apply(1'b1, 8'h12, 8'h34);
    check_eq("V1_12+34", observed(), 9'h046);

    apply(1'b0, 8'hFF, 8'hFF);
    check_eq("V_drop_with_operand_change", observed(), 9'h000);

    bus.V = 1'b0;
    bus.b = 'x;
    bus.c = 'x;
    @(posedge clk);
    #1;
    check_eq("V0_x_operands", observed(), 9'h000);

    apply(1'b1, 8'h10, 8'h20);
    check_eq("pre_reset_10+20", observed(), 9'h030);
    rst_n = 1'b0;
    apply(1'b1, 8'h10, 8'h20);
    check_eq("mid_stream_reset", observed(), 9'h000);
    rst_n = 1'b1;
    apply(1'b1, 8'h10, 8'h20);
    check_eq("first_post_reset", observed(), 9'h030);

    for (int i = 0; i < 1000; i++) begin
      rb = relay_byte_t'($urandom_range(0, 255));
      rc = relay_byte_t'($urandom_range(0, 255));
      apply(1'b1, rb, rc);
      check_eq($sformatf("rand%0d_%h+%h", i, rb, rc), observed(), {1'b0, rb} + {1'b0, rc});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_eight_bit_adder_unit
